// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit in EX: single-edge multiply, 32-step restoring divide.
// Holds the front of the pipeline via STALL until the result registers; DONE pulses for one FIN cycle.
module ex_muldiv_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [4:0]  EX_ALU_SELECT,
    input  logic [31:0] OPERAND1,
    input  logic [31:0] OPERAND2,
    input  logic        KILL,
    output logic        STALL,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_code;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_dvs;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [5:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_done;

    logic        w_is_m;
    logic        w_accept;
    logic [31:0] w_in_abs1;
    logic [31:0] w_in_abs2;
    logic        w_div_signed;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_div_special;
    logic        w_cnt_done;
    logic [32:0] w_trial;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [31:0] w_quo_f;
    logic [31:0] w_rem_f;
    logic [31:0] w_result;
    logic        w_load;

    assign w_is_m   = START && (EX_ALU_SELECT[4:3] == 2'b01);
    assign w_accept = (r_state == S_IDLE) && w_is_m && !KILL;

    // Divide magnitudes are formed at accept so the first iteration can start on the next edge.
    assign w_in_abs1 = (!EX_ALU_SELECT[0] && OPERAND1[31]) ? -OPERAND1 : OPERAND1;
    assign w_in_abs2 = (!EX_ALU_SELECT[0] && OPERAND2[31]) ? -OPERAND2 : OPERAND2;

    assign w_div_signed  = !r_code[0];
    assign w_div_zero    = (r_op2 == 32'h0000_0000);
    assign w_div_ovf     = w_div_signed && (r_op1 == 32'h8000_0000) && (r_op2 == 32'hFFFF_FFFF);
    assign w_div_special = w_div_zero || w_div_ovf;
    assign w_cnt_done    = (r_cnt == 6'd32);
    assign w_trial       = {r_rem, r_quo[31]} - {1'b0, r_dvs};

    // Sign-extend to 64 bits; the low 64 bits of the product are then exact for every variant.
    assign w_mul_a = {{32{(r_code != 2'b11) && r_op1[31]}}, r_op1};
    assign w_mul_b = {{32{(r_code == 2'b01) && r_op2[31]}}, r_op2};
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_quo_f = (w_div_signed && (r_op1[31] ^ r_op2[31])) ? -r_quo : r_quo;
    assign w_rem_f = (w_div_signed && r_op1[31]) ? -r_rem : r_rem;

    always_comb begin
        w_result = 32'h0000_0000;
        if (r_state == S_MUL) begin
            w_result = (r_code == 2'b00) ? w_prod[31:0] : w_prod[63:32];
        end else if (w_div_zero) begin
            w_result = r_code[1] ? r_op1 : 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
            w_result = r_code[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else begin
            w_result = r_code[1] ? w_rem_f : w_quo_f;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        STALL  = 1'b0;
        case (r_state)
            S_IDLE: begin
                STALL = w_is_m && !KILL;
                if (w_accept) begin
                    w_next = EX_ALU_SELECT[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                STALL  = 1'b1;
                w_next = KILL ? S_IDLE : S_FIN;
            end
            S_DIV: begin
                STALL = 1'b1;
                if (KILL) begin
                    w_next = S_IDLE;
                end else if (w_div_special || w_cnt_done) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_load = ((r_state == S_MUL) || (r_state == S_DIV)) && (w_next == S_FIN);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_code   <= 2'b00;
            r_op1    <= 32'h0000_0000;
            r_op2    <= 32'h0000_0000;
            r_dvs    <= 32'h0000_0000;
            r_quo    <= 32'h0000_0000;
            r_rem    <= 32'h0000_0000;
            r_cnt    <= 6'd0;
            r_result <= 32'h0000_0000;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_result <= w_result;
            end
            if (w_accept) begin
                r_code <= EX_ALU_SELECT[1:0];
                r_op1  <= OPERAND1;
                r_op2  <= OPERAND2;
                r_dvs  <= w_in_abs2;
                r_quo  <= w_in_abs1;
                r_rem  <= 32'h0000_0000;
                r_cnt  <= 6'd0;
            end else if ((r_state == S_DIV) && !w_cnt_done && !w_div_special) begin
                // Restoring step: the quotient register doubles as the dividend shift-out.
                if (!w_trial[32]) begin
                    r_rem <= w_trial[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end else begin
                    r_rem <= {r_rem[30:0], r_quo[31]};
                    r_quo <= {r_quo[30:0], 1'b0};
                end
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    assign DONE   = r_done;
    assign RESULT = r_result;

endmodule
